jcnt_param: RTL

//   Parametrised Johnson (twisted-ring) counter, 2*WIDTH states, with enable, up/down

---
 rtl/jcnt_param_if.sv | 44 ++++
 rtl/jcnt_param.sv | 110 +++++++++++
 2 files changed

// File: rtl/jcnt_param_if.sv
// ---------------------------------------------------------------------------
// jcnt_param_if
//   Control/status bundle for the parametrised Johnson counter.
//   master modport : drives en/dir/clr/load/load_idx, observes counter outputs
//   slave  modport : the counter itself
//   Signals:
//     en        advance one state this cycle
//     dir       0 = forward (index +1), 1 = reverse (index -1)
//     clr       synchronous clear to state 0
//     load      synchronous load of state load_idx
//     load_idx  state index to load (IW bits)
//     q         Johnson code (WIDTH bits, registered)
//     idx       binary index of q, 0 when q is illegal
//     dec       one-hot of idx (N bits), all-zero when q is illegal
//     wrap      one-cycle pulse on an N-1 <-> 0 step
//     err       one-cycle pulse on illegal q or out-of-range load_idx
// ---------------------------------------------------------------------------
interface jcnt_param_if #(
  parameter int WIDTH = 4
);
  localparam int N  = 2 * WIDTH;
  localparam int IW = $clog2(N);

  logic          en;
  logic          dir;
  logic          clr;
  logic          load;
  logic [IW-1:0] load_idx;
  logic [WIDTH-1:0] q;
  logic [IW-1:0] idx;
  logic [N-1:0]  dec;
  logic          wrap;
  logic          err;

  modport master (
    output en, dir, clr, load, load_idx,
    input  q, idx, dec, wrap, err
  );

  modport slave (
    input  en, dir, clr, load, load_idx,
    output q, idx, dec, wrap, err
  );
endinterface

// File: rtl/jcnt_param.sv
// ---------------------------------------------------------------------------
// jcnt_param
//   Parametrised Johnson (twisted-ring) counter with 2*WIDTH states.
//   Supports enable, up/down direction, synchronous clear, indexed load,
//   illegal-state detection (optionally self-correcting to state 0) and
//   binary / one-hot decode of the current state.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-low reset
//     bus   jcnt_param_if slave modport (controls in, q/idx/dec/wrap/err out)
//   Parameters:
//     WIDTH         ring length in flops (>= 2); state count N = 2*WIDTH
//     SELF_CORRECT  1: an illegal q is forced to 0 on the next edge
//                   0: an illegal q is held and flagged every cycle
// ---------------------------------------------------------------------------
module jcnt_param #(
  parameter int WIDTH        = 4,
  parameter bit SELF_CORRECT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  jcnt_param_if.slave bus
);
  localparam int N   = 2 * WIDTH;
  localparam int IW  = $clog2(N);
  localparam int IW1 = IW + 1;

  // Johnson code of state k: k in 1..WIDTH fills from the top,
  // k in WIDTH+1..N-1 leaves the low N-k bits set.
  function automatic logic [WIDTH-1:0] code_f(input int k);
    logic [WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (k <= WIDTH) c[i] = (i >= WIDTH - k);
      else            c[i] = (i < N - k);
    end
    return c;
  endfunction

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] code_tbl [N];
  logic [N-1:0]     match;
  logic [IW-1:0]    idx_c;
  logic             legal;
  logic             load_ok;

  // One comparator per legal code; the codes are distinct so at most one
  // match bit is ever set, which makes match directly the one-hot decode.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_code
      assign code_tbl[gi] = code_f(gi);
      assign match[gi]    = (q_q == code_tbl[gi]);
    end
  endgenerate

  always_comb begin
    idx_c = '0;
    for (int k = 0; k < N; k++) begin
      if (match[k]) idx_c = idx_c | IW'(k);
    end
  end

  assign legal   = |match;
  // Extra bit so the range check also works when N is a power of two.
  assign load_ok = ({1'b0, bus.load_idx} < IW1'(N));

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (bus.clr) begin
      q_d = '0;
    end else if (bus.load) begin
      if (load_ok) q_d   = code_tbl[bus.load_idx];
      else         err_d = 1'b1;
    end else if (!legal) begin
      err_d = 1'b1;
      if (SELF_CORRECT) q_d = '0;
    end else if (bus.en) begin
      if (!bus.dir) begin
        q_d    = {~q_q[0], q_q[WIDTH-1:1]};
        wrap_d = (idx_c == IW'(N - 1));
      end else begin
        q_d    = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
        wrap_d = (idx_c == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.idx  = idx_c;
  assign bus.dec  = match;
  assign bus.wrap = wrap_q;
  assign bus.err  = err_q;
endmodule
